// File: rtl/inst_fetch_queue_if.sv
// Decode-side handshake of the fetch queue.
// The master drives the head entry and the slave supplies ready.
interface inst_fetch_queue_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic [PC_W-1:0]   out_pcadd;

  modport master (
    output out_valid, out_inst, out_pc, out_pcadd,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_inst, out_pc, out_pcadd,
    output out_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: PC owner, async imem read,
// DEPTH-entry {pc,inst} FIFO towards decode, redirect flush.
module inst_fetch_queue #(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter bit              WRAP_EN  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INST_W-1:0]        imem_rdata,
  input  logic                     redirect_valid,
  input  logic [PC_W-1:0]          redirect_pc,
  inst_fetch_queue_if.master       deq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  ent_t            mem [DEPTH];
  ent_t            head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [PC_W-1:0] fetch_pc;
  logic            full;
  logic            pc_max;
  logic            push;
  logic            pop;
  logic            valid;

  // A pop in the same cycle does not free a slot for the push.
  always_comb begin
    full   = (count == CW'(DEPTH));
    pc_max = &fetch_pc;
    push   = !redirect_valid && !halted && !full;
    valid  = (count != '0) && !redirect_valid;
    pop    = valid && deq.out_ready;
    head   = mem[rd_ptr];
  end

  assign imem_addr     = fetch_pc;
  assign deq.out_valid = valid;
  assign deq.out_inst  = head.inst;
  assign deq.out_pc    = head.pc;
  assign deq.out_pcadd = head.pc + PC_W'(1);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {fetch_pc, imem_rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      halted   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (pc_max && !WRAP_EN)
          halted <= 1'b1;
        else
          fetch_pc <= fetch_pc + PC_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: wrapping and halting instances
// share stimulus and are checked against a queue model.
module tb_inst_fetch_queue;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       redir = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] rpc = 8'h00;

  logic [7:0]  addr0, addr1;
  logic [31:0] rdata0, rdata1;
  logic [2:0]  cnt0, cnt1;
  logic        hlt0, hlt1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [7:0] a);
    return 32'h100 + 32'(a);
  endfunction

  assign rdata0 = imem(addr0);
  assign rdata1 = imem(addr1);

  inst_fetch_queue_if #(.PC_W(8), .INST_W(32)) q0 ();
  inst_fetch_queue_if #(.PC_W(8), .INST_W(32)) q1 ();
  assign q0.out_ready = ready;
  assign q1.out_ready = ready;

  inst_fetch_queue #(.PC_W(8), .INST_W(32), .DEPTH(D),
    .RESET_PC(8'h00), .WRAP_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst),
    .imem_addr(addr0), .imem_rdata(rdata0),
    .redirect_valid(redir), .redirect_pc(rpc),
    .deq(q0), .count(cnt0), .halted(hlt0)
  );

  inst_fetch_queue #(.PC_W(8), .INST_W(32), .DEPTH(D),
    .RESET_PC(8'h00), .WRAP_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst),
    .imem_addr(addr1), .imem_rdata(rdata1),
    .redirect_valid(redir), .redirect_pc(rpc),
    .deq(q1), .count(cnt1), .halted(hlt1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of fetched entries per instance.
  typedef struct {
    logic [7:0]  pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mq [2][$];
  int   mpc [2];
  bit   mh [2];
  bit   live = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit ps;
      if (rst) begin
        live = 1'b1;
        mq[i].delete();
        mpc[i] = 0;
        mh[i] = 1'b0;
      end else if (redir) begin
        mq[i].delete();
        mpc[i] = int'(rpc);
        mh[i] = 1'b0;
      end else begin
        ps = !mh[i] && (mq[i].size() < D);
        if (mq[i].size() > 0 && ready)
          void'(mq[i].pop_front());
        if (ps) begin
          mq[i].push_back('{pc: 8'(mpc[i]), inst: imem(8'(mpc[i]))});
          if (mpc[i] == 255) begin
            if (i == 0) mpc[i] = 0;
            else mh[i] = 1'b1;
          end else begin
            mpc[i] = mpc[i] + 1;
          end
        end
      end
    end
  end

  task automatic cmp(input int i, input logic [7:0] a,
                     input logic v, input logic [7:0] pc,
                     input logic [31:0] inst, input logic [7:0] pca,
                     input logic [2:0] c, input logic h);
    bit ev;
    logic [7:0] epca;
    ev = (mq[i].size() != 0) && !redir;
    chk($sformatf("m%0d imem_addr", i), 32'(a), 32'(mpc[i]));
    chk($sformatf("m%0d count", i), 32'(c), 32'(mq[i].size()));
    chk($sformatf("m%0d halted", i), 32'(h), 32'(mh[i]));
    chk($sformatf("m%0d out_valid", i), 32'(v), 32'(ev));
    if (ev) begin
      epca = mq[i][0].pc + 8'd1;
      chk($sformatf("m%0d out_pc", i), 32'(pc), 32'(mq[i][0].pc));
      chk($sformatf("m%0d out_inst", i), inst, mq[i][0].inst);
      chk($sformatf("m%0d out_pcadd", i), 32'(pca), 32'(epca));
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      cmp(0, addr0, q0.out_valid, q0.out_pc, q0.out_inst,
          q0.out_pcadd, cnt0, hlt0);
      cmp(1, addr1, q1.out_valid, q1.out_pc, q1.out_inst,
          q1.out_pcadd, cnt1, hlt1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, streaming with ready high
    rst = 1'b1; ready = 1'b1;
    step(); step();
    chk("t1 rst valid", 32'(q0.out_valid), 32'd0);
    chk("t1 rst count", 32'(cnt0), 32'd0);
    chk("t1 rst halted", 32'(hlt0), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1 valid", 32'(q0.out_valid), 32'd1);
      chk("t1 pc", 32'(q0.out_pc), 32'(k));
      chk("t1 inst", q0.out_inst, 32'h100 + 32'(k));
    end

    // Back-pressure fills the queue, then drains in order
    rst = 1'b1;
    step();
    rst = 1'b0; ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t2 count", 32'(cnt0), 32'((k < 4) ? k : 4));
    end
    chk("t2 imem_addr", 32'(addr0), 32'd4);
    chk("t2 head", 32'(q0.out_pc), 32'd0);
    ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t2 drain pc", 32'(q0.out_pc), 32'(k));
    end

    // Redirect with a full queue
    ready = 1'b0;
    repeat (5) step();
    chk("t3 full", 32'(cnt0), 32'd4);
    redir = 1'b1; rpc = 8'h40;
    #1;
    chk("t3 redir valid", 32'(q0.out_valid), 32'd0);
    step();
    redir = 1'b0;
    chk("t3 count", 32'(cnt0), 32'd0);
    chk("t3 imem_addr", 32'(addr0), 32'h40);
    ready = 1'b1;
    step();
    chk("t3 pc", 32'(q0.out_pc), 32'h40);
    chk("t3 valid", 32'(q0.out_valid), 32'd1);

    // PC max: wrap on dut0, halt on dut1
    redir = 1'b1; rpc = 8'hFE;
    step();
    redir = 1'b0;
    step();
    chk("t4 pc fe", 32'(q0.out_pc), 32'hFE);
    chk("t5 pc fe", 32'(q1.out_pc), 32'hFE);
    step();
    chk("t4 pc ff", 32'(q0.out_pc), 32'hFF);
    chk("t4 pcadd ff", 32'(q0.out_pcadd), 32'h00);
    chk("t5 pc ff", 32'(q1.out_pc), 32'hFF);
    step();
    chk("t4 pc 00", 32'(q0.out_pc), 32'h00);
    chk("t5 valid", 32'(q1.out_valid), 32'd0);
    chk("t5 halted", 32'(hlt1), 32'd1);
    chk("t5 addr hold", 32'(addr1), 32'hFF);
    step();
    chk("t4 pc 01", 32'(q0.out_pc), 32'h01);
    redir = 1'b1; rpc = 8'h10;
    step();
    redir = 1'b0;
    chk("t5 unhalt", 32'(hlt1), 32'd0);
    step();
    chk("t5 pc 10", 32'(q1.out_pc), 32'h10);
    chk("t5 valid 10", 32'(q1.out_valid), 32'd1);

    // Reset mid-stream wins over a simultaneous redirect
    rst = 1'b1;
    step();
    rst = 1'b0; ready = 1'b0;
    repeat (3) step();
    chk("t6 count3", 32'(cnt0), 32'd3);
    rst = 1'b1; redir = 1'b1; rpc = 8'h77;
    step();
    rst = 1'b0; redir = 1'b0;
    chk("t6 count", 32'(cnt0), 32'd0);
    chk("t6 valid", 32'(q0.out_valid), 32'd0);
    chk("t6 imem_addr", 32'(addr0), 32'd0);

    // Random traffic with changing ready bias
    for (int n = 0; n < 3000; n++) begin
      int bias;
      bias = (n / 250) % 4;
      rst = ($urandom_range(0, 149) == 0);
      redir = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1)
        rpc = 8'($urandom_range(0, 255));
      else
        rpc = 8'hF8 + 8'($urandom_range(0, 7));
      ready = ($urandom_range(0, 3) >= bias);
      step();
    end

    rst = 1'b0; redir = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
